risc_v_mike_uart_loader: RTL and testbench

RISC_V_MIKE_UART_LOADER -- requirements
Module: risc_v_mike_uart_loader

---
 rtl/risc_v_mike_uart_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_risc_v_mike_uart_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mike_uart_loader.sv
// UART boot loader: receives a length-prefixed stream of 32-bit instruction words
// over 8N1 serial and writes them into instruction memory while holding the core in reset.
module risc_v_mike_uart_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_WIDTH  = 10,
    parameter int START_ADDR  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  frame_err
);
    localparam int CNT_W = $clog2(CLK_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_DONE} ld_state_t;

    // rx_prev_q delays the synchronized line once more for falling-edge detection.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid, byte_bad;

    ld_state_t             ld_state_q, ld_state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_asm_q, word_asm_d;
    logic [31:0]           asm_next;
    logic                  last_q, last_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  core_hold_q, core_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                    else                   bit_cnt_d  = bit_cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rx_sync_q;
                    byte_bad   = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Each lane of the assembly register takes the received byte only when selected.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[gi*8 +: 8] = (byte_idx_q == 2'(gi)) ? shift_q : word_asm_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        ld_state_d   = ld_state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_asm_d   = word_asm_q;
        last_d       = last_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_hold_d  = core_hold_q;
        load_done_d  = 1'b0;
        frame_err_d  = frame_err_q | byte_bad;
        case (ld_state_q)
            LD_LEN_LO: begin
                if (byte_valid) begin
                    len_d[7:0] = shift_q;
                    ld_state_d = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (byte_valid) begin
                    len_d[15:8] = shift_q;
                    byte_idx_d  = '0;
                    word_idx_d  = '0;
                    if ({shift_q, len_q[7:0]} == 16'd0) begin
                        ld_state_d  = LD_DONE;
                        load_done_d = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        ld_state_d = LD_WORD;
                    end
                end
            end
            LD_WORD: begin
                // last_q delays completion so load_done follows the final write by one cycle.
                if (last_q) begin
                    last_d      = 1'b0;
                    ld_state_d  = LD_DONE;
                    load_done_d = 1'b1;
                    core_hold_d = 1'b0;
                end else if (byte_valid) begin
                    word_asm_d = asm_next;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = asm_next;
                        imem_addr_d  = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(word_idx_q);
                        word_idx_d   = word_idx_q + 16'd1;
                        last_d       = (word_idx_q + 16'd1 == len_q);
                    end
                end
            end
            default: ;
        endcase
        if (byte_bad && ld_state_q != LD_DONE) begin
            ld_state_d = LD_LEN_LO;
            byte_idx_d = '0;
            word_idx_d = '0;
            word_asm_d = '0;
            last_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ld_state_q   <= LD_LEN_LO;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_asm_q   <= '0;
            last_q       <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ld_state_q   <= ld_state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_asm_q   <= word_asm_d;
            last_q       <= last_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_risc_v_mike_uart_loader.sv
// Table-driven bench for the UART loader: serial streams in, imem writes and status checked.
module tb_risc_v_mike_uart_loader;
    localparam int CPB = 16;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold, load_done, frame_err;

    risc_v_mike_uart_loader #(.CLK_PER_BIT(CPB), .ADDR_WIDTH(AW), .START_ADDR(2)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] we_addr_q[$];
    logic [31:0]   we_data_q[$];
    int last_we_cyc = 0, done_cyc = 0, done_cnt = 0, stop_cyc = 0;
    int checks = 0, errors = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            we_addr_q.push_back(imem_addr);
            we_data_q.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    typedef struct {
        string        name;
        int           nb;
        logic [111:0] bytes;
        int           bad_idx;
        int           exp_n;
        logic [95:0]  exp_words;
        int           exp_done;
        logic         exp_hold;
        logic         exp_ferr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        we_addr_q.delete();
        we_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        stop_cyc = cyc;
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_stream(input logic [111:0] bytes, input int nb, input int bad_idx);
        for (int i = 0; i < nb; i++) send_byte(bytes[i*8 +: 8], (i == bad_idx) ? 1'b0 : 1'b1);
        repeat (40) @(negedge clk);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"n1", 6, {8'h00, 8'h20, 8'h00, 8'h93, 8'h00, 8'h01}, -1, 1,
                    {64'h0, 32'h00200093}, 1, 1'b0, 1'b0};
        vecs[1] = '{"n3", 14, {8'hff, 8'h9f, 8'hf0, 8'h6f, 8'h00, 8'h40, 8'h01, 8'h13,
                    8'h00, 8'h20, 8'h00, 8'h93, 8'h00, 8'h03}, -1, 3,
                    {32'hff9ff06f, 32'h00400113, 32'h00200093}, 1, 1'b0, 1'b0};
        vecs[2] = '{"n0", 2, 112'h0, -1, 0, 96'h0, 1, 1'b0, 1'b0};
        vecs[3] = '{"badstop", 6, {8'h00, 8'h20, 8'h00, 8'h93, 8'h00, 8'h01}, 5, 0,
                    96'h0, 0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        do_reset();
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_stream(vecs[v].bytes, vecs[v].nb, vecs[v].bad_idx);
            $display("vector %s: writes=%0d load_done=%0d core_hold=%0b frame_err=%0b",
                     vecs[v].name, we_addr_q.size(), done_cnt, core_hold, frame_err);
            chk({vecs[v].name, "_nwr"}, 32'(we_addr_q.size()), 32'(vecs[v].exp_n));
            for (int k = 0; k < vecs[v].exp_n; k++) begin
                if (k < we_addr_q.size()) begin
                    chk({vecs[v].name, "_addr"}, 32'(we_addr_q[k]), 32'(2 + k));
                    chk({vecs[v].name, "_data"}, we_data_q[k], vecs[v].exp_words[k*32 +: 32]);
                end
            end
            chk({vecs[v].name, "_done"}, 32'(done_cnt), 32'(vecs[v].exp_done));
            chk({vecs[v].name, "_hold"}, 32'(core_hold), 32'(vecs[v].exp_hold));
            chk({vecs[v].name, "_ferr"}, 32'(frame_err), 32'(vecs[v].exp_ferr));
            if (vecs[v].exp_n > 0 && done_cnt > 0) begin
                chk({vecs[v].name, "_done_lat"}, 32'(done_cyc - last_we_cyc), 32'd1);
                chk({vecs[v].name, "_hold_addr"}, 32'(imem_addr), 32'(1 + vecs[v].exp_n));
                chk({vecs[v].name, "_hold_data"}, imem_wdata,
                    vecs[v].exp_words[(vecs[v].exp_n-1)*32 +: 32]);
            end
            if (vecs[v].exp_n == 0 && done_cnt > 0)
                chk({vecs[v].name, "_done_in_stop"},
                    32'((done_cyc - stop_cyc >= 2) && (done_cyc - stop_cyc <= 16)), 32'd1);
        end

        // Recovery after the framing error: a valid stream still loads at addr 2.
        send_stream(vecs[0].bytes, vecs[0].nb, -1);
        $display("after framing error: writes=%0d frame_err=%0b", we_addr_q.size(), frame_err);
        chk("recov_nwr", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() > 0) begin
            chk("recov_addr", 32'(we_addr_q[0]), 32'd2);
            chk("recov_data", we_data_q[0], 32'h00200093);
        end
        chk("recov_ferr_sticky", 32'(frame_err), 32'd1);
        chk("recov_hold", 32'(core_hold), 32'd0);

        // LD_DONE is terminal: a further stream is ignored.
        send_stream({8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h01}, 6, -1);
        $display("after done: writes=%0d load_done=%0d", we_addr_q.size(), done_cnt);
        chk("term_nwr", 32'(we_addr_q.size()), 32'd1);
        chk("term_done", 32'(done_cnt), 32'd1);
        chk("term_hold", 32'(core_hold), 32'd0);

        // Short low glitch on idle line must not be taken as a start bit.
        do_reset();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_nwr", 32'(we_addr_q.size()), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        send_stream(vecs[0].bytes, vecs[0].nb, -1);
        $display("after glitch: writes=%0d", we_addr_q.size());
        chk("glitch_then_nwr", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() > 0) chk("glitch_then_data", we_data_q[0], 32'h00200093);

        // Reset in the middle of a word abandons it; the next stream loads cleanly.
        do_reset();
        send_stream({8'h00, 8'h93, 8'h00, 8'h01}, 4, -1);
        chk("midrst_nwr_before", 32'(we_addr_q.size()), 32'd0);
        do_reset();
        send_stream({8'hde, 8'had, 8'hbe, 8'hef, 8'h00, 8'h01}, 6, -1);
        $display("after mid-load reset: writes=%0d", we_addr_q.size());
        chk("midrst_nwr", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() > 0) begin
            chk("midrst_addr", 32'(we_addr_q[0]), 32'd2);
            chk("midrst_data", we_data_q[0], 32'hdeadbeef);
        end
        chk("midrst_done", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
